// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issue stage in front of the combinational ALU.
// Accepts ALU op / LOAD / CLEAR commands, drives registered operands to the
// ALU, captures its result after ALU_LAT cycles into the accumulator and
// presents it on a valid/ready response port.
// Optional feature macro: ALU_SEQ_STICKY_CARRY_EN (sticky carry register).
module alu_cmd_sequencer #(
  parameter int WIDTH   = 6,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] acc_q,
  output logic             sticky_carry
);

  localparam logic [3:0] OP_LOAD  = 4'b1111;
  localparam logic [3:0] OP_CLEAR = 4'b1110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] lat_cnt;

  generate
    if (ALU_LAT < 1 || ALU_LAT > 7) begin : g_bad_alu_lat
      $error("alu_cmd_sequencer: ALU_LAT must be within 1..7");
    end
  endgenerate

  assign cmd_ready = (state_q == IDLE);

  // Next-state decode: LOAD/CLEAR skip the ALU, other codes wait out the latency
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_LOAD || cmd_op == OP_CLEAR) begin
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (lat_cnt == 3'd0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: operand launch, latency count, result capture into accumulator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q     <= '0;
      alu_ctrl  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_valid <= 1'b0;
      lat_cnt   <= '0;
    end else begin
      rsp_valid <= (state_d == RESP);
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_op == OP_LOAD) begin
              acc_q     <= cmd_imm;
              rsp_data  <= cmd_imm;
              rsp_carry <= 1'b0;
              rsp_zero  <= (cmd_imm == '0);
            end else if (cmd_op == OP_CLEAR) begin
              acc_q     <= '0;
              rsp_data  <= '0;
              rsp_carry <= 1'b0;
              rsp_zero  <= 1'b1;
            end else begin
              alu_ctrl <= cmd_op;
              alu_a    <= acc_q;
              alu_b    <= cmd_imm;
              lat_cnt  <= 3'(ALU_LAT - 1);
            end
          end
        end
        ISSUE: begin
          if (lat_cnt != 3'd0) begin
            lat_cnt <= lat_cnt - 3'd1;
          end else begin
            acc_q     <= alu_out;
            rsp_data  <= alu_out;
            rsp_carry <= alu_carry;
            rsp_zero  <= alu_zero;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_CARRY_EN
  logic sticky_q;

  // Sticky carry: set by any ALU capture reporting carry, cleared by CLEAR
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (state_q == IDLE && cmd_valid && cmd_op == OP_CLEAR) begin
      sticky_q <= 1'b0;
    end else if (state_q == ISSUE && lat_cnt == 3'd0 && alu_carry) begin
      sticky_q <= 1'b1;
    end
  end

  assign sticky_carry = sticky_q;
`else
  assign sticky_carry = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: scoreboard bench for alu_cmd_sequencer.
// Two instances: ALU_LAT=1 for the main command stream, ALU_LAT=3 for the
// longer-latency and mid-ISSUE reset cases. A behavioural ALU sits on each.
module tb_alu_cmd_sequencer;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_BAD   = 4'b1010;
  localparam logic [3:0] OP_CLEAR = 4'b1110;
  localparam logic [3:0] OP_LOAD  = 4'b1111;

`ifdef ALU_SEQ_STICKY_CARRY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  typedef struct packed {
    logic [5:0] data;
    logic       carry;
    logic       zero;
    logic       sticky;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [5:0] acc_m = '0;
  logic       sticky_m = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with ALU_LAT = 1
  logic       rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [3:0] cmd_op, alu_ctrl;
  logic [5:0] cmd_imm, alu_a, alu_b, alu_out, rsp_data, acc_q;
  logic       alu_carry, alu_zero, rsp_carry, rsp_zero, sticky_carry;

  // Instance with ALU_LAT = 3
  logic       rst_n_3, cmd_valid_3, cmd_ready_3, rsp_valid_3, rsp_ready_3;
  logic [3:0] cmd_op_3, alu_ctrl_3;
  logic [5:0] cmd_imm_3, alu_a_3, alu_b_3, alu_out_3, rsp_data_3, acc_q_3;
  logic       alu_carry_3, alu_zero_3, rsp_carry_3, rsp_zero_3, sticky_carry_3;

  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [5:0] a,
                                        input logic [5:0] b);
    logic [6:0] s;
    logic [5:0] o;
    logic       c;
    s = '0;
    o = '0;
    c = 1'b0;
    case (op)
      OP_AND: o = a & b;
      OP_OR:  o = a | b;
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; o = s[5:0]; c = s[6]; end
      OP_SUB: begin s = {1'b0, a} - {1'b0, b}; o = s[5:0]; c = s[6]; end
      default: o = '0;
    endcase
    return {c, (o == 6'd0), o};
  endfunction

  assign {alu_carry, alu_zero, alu_out}       = alu_fn(alu_ctrl, alu_a, alu_b);
  assign {alu_carry_3, alu_zero_3, alu_out_3} = alu_fn(alu_ctrl_3, alu_a_3, alu_b_3);

  alu_cmd_sequencer #(.WIDTH(6), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_imm(cmd_imm), .alu_ctrl(alu_ctrl), .alu_a(alu_a),
    .alu_b(alu_b), .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .acc_q(acc_q),
    .sticky_carry(sticky_carry)
  );

  alu_cmd_sequencer #(.WIDTH(6), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n_3), .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready_3),
    .cmd_op(cmd_op_3), .cmd_imm(cmd_imm_3), .alu_ctrl(alu_ctrl_3), .alu_a(alu_a_3),
    .alu_b(alu_b_3), .alu_out(alu_out_3), .alu_carry(alu_carry_3), .alu_zero(alu_zero_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_data(rsp_data_3),
    .rsp_carry(rsp_carry_3), .rsp_zero(rsp_zero_3), .acc_q(acc_q_3),
    .sticky_carry(sticky_carry_3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one command into the ALU_LAT=1 instance, score its response,
  // optionally holding rsp_ready low for 'hold' cycles once it is valid.
  task automatic applyStimulus(input logic [3:0] op, input logic [5:0] imm, input int hold);
    exp_t       e;
    exp_t       got;
    logic [7:0] r;
    logic [5:0] a_before;
    int         exp_lat;
    int         lat;
    int         w;
    bit         is_alu;

    a_before = acc_m;
    is_alu   = (op != OP_LOAD) && (op != OP_CLEAR);
    if (op == OP_LOAD) begin
      e.data = imm; e.carry = 1'b0; e.zero = (imm == 6'd0);
      exp_lat = 1;
    end else if (op == OP_CLEAR) begin
      e.data = '0; e.carry = 1'b0; e.zero = 1'b1;
      sticky_m = 1'b0;
      exp_lat = 1;
    end else begin
      r = alu_fn(op, acc_m, imm);
      e.data = r[5:0]; e.carry = r[7]; e.zero = r[6];
      if (STICKY_ON && r[7]) sticky_m = 1'b1;
      exp_lat = 2;
    end
    acc_m    = e.data;
    e.sticky = sticky_m;
    exp_q.push_back(e);

    w = 0;
    while (!cmd_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    checkOutput("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_imm   = imm;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;

    lat = 1;
    while (!rsp_valid && lat < 20) begin
      if (is_alu) begin
        checkOutput("issue_alu_a", 32'(alu_a), 32'(a_before));
        checkOutput("issue_alu_b", 32'(alu_b), 32'(imm));
        checkOutput("issue_alu_ctrl", 32'(alu_ctrl), 32'(op));
      end
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("rsp_latency", 32'(lat), 32'(exp_lat));

    got = exp_q.pop_front();
    checkOutput("rsp_data", 32'(rsp_data), 32'(got.data));
    checkOutput("rsp_carry", 32'(rsp_carry), 32'(got.carry));
    checkOutput("rsp_zero", 32'(rsp_zero), 32'(got.zero));
    checkOutput("acc_q", 32'(acc_q), 32'(got.data));
    checkOutput("sticky_carry", 32'(sticky_carry), 32'(got.sticky));

    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = OP_LOAD;
      cmd_imm   = 6'h2A;
      @(posedge clk); #1;
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_data", 32'(rsp_data), 32'(got.data));
      checkOutput("bp_rsp_carry", 32'(rsp_carry), 32'(got.carry));
      checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("bp_acc_q", 32'(acc_q), 32'(got.data));
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;

    @(posedge clk); #1;
    checkOutput("drain_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("drain_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("drain_acc_q", 32'(acc_q), 32'(got.data));
  endtask

  // Safety net in case some wait outside the bounded loops stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence
  initial begin
    logic [3:0] ops [5];
    int         seen;
    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_LOAD};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_imm = '0; rsp_ready = 1'b1;
    rst_n_3 = 1'b0; cmd_valid_3 = 1'b0; cmd_op_3 = '0; cmd_imm_3 = '0; rsp_ready_3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_acc_q", 32'(acc_q), 32'd0);
    checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
    checkOutput("rst_alu_b", 32'(alu_b), 32'd0);
    checkOutput("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("rst_sticky", 32'(sticky_carry), 32'd0);
    rst_n = 1'b1;
    rst_n_3 = 1'b1;

    applyStimulus(OP_LOAD, 6'd5, 0);
    applyStimulus(OP_ADD, 6'd3, 0);
    applyStimulus(OP_SUB, 6'd9, 4);
    applyStimulus(OP_ADD, 6'h01, 0);
    applyStimulus(OP_OR, 6'h15, 0);
    applyStimulus(OP_AND, 6'h0F, 0);
    applyStimulus(OP_BAD, 6'h07, 0);
    applyStimulus(OP_LOAD, 6'h00, 0);
    applyStimulus(OP_LOAD, 6'h3E, 0);
    applyStimulus(OP_ADD, 6'h05, 0);
    applyStimulus(OP_CLEAR, 6'h3F, 1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(ops[$urandom_range(0, 4)], 6'($urandom_range(0, 63)), 0);
    end

    // ALU_LAT=3: load 0x20, then 0x20 + 0x20 wraps to zero with carry
    cmd_valid_3 = 1'b1; cmd_op_3 = OP_LOAD; cmd_imm_3 = 6'h20;
    @(posedge clk); #1;
    cmd_valid_3 = 1'b0;
    checkOutput("lat3_load_valid", 32'(rsp_valid_3), 32'd1);
    checkOutput("lat3_load_data", 32'(rsp_data_3), 32'h20);
    @(posedge clk); #1;
    cmd_valid_3 = 1'b1; cmd_op_3 = OP_ADD; cmd_imm_3 = 6'h20;
    @(posedge clk); #1;
    cmd_valid_3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("lat3_issue_valid", 32'(rsp_valid_3), 32'd0);
      checkOutput("lat3_alu_a", 32'(alu_a_3), 32'h20);
      checkOutput("lat3_alu_b", 32'(alu_b_3), 32'h20);
      @(posedge clk); #1;
    end
    checkOutput("lat3_rsp_valid", 32'(rsp_valid_3), 32'd1);
    checkOutput("lat3_rsp_data", 32'(rsp_data_3), 32'd0);
    checkOutput("lat3_rsp_carry", 32'(rsp_carry_3), 32'd1);
    checkOutput("lat3_rsp_zero", 32'(rsp_zero_3), 32'd1);
    checkOutput("lat3_sticky", 32'(sticky_carry_3), 32'(STICKY_ON));
    @(posedge clk); #1;

    // ALU_LAT=3: reset while a command is in ISSUE discards it
    cmd_valid_3 = 1'b1; cmd_op_3 = OP_LOAD; cmd_imm_3 = 6'h11;
    @(posedge clk); #1;
    cmd_valid_3 = 1'b0;
    @(posedge clk); #1;
    cmd_valid_3 = 1'b1; cmd_op_3 = OP_ADD; cmd_imm_3 = 6'h05;
    @(posedge clk); #1;
    cmd_valid_3 = 1'b0;
    checkOutput("mid_issue_alu_a", 32'(alu_a_3), 32'h11);
    rst_n_3 = 1'b0;
    @(posedge clk); #1;
    rst_n_3 = 1'b1;
    checkOutput("mid_rst_cmd_ready", 32'(cmd_ready_3), 32'd1);
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid_3), 32'd0);
    checkOutput("mid_rst_acc_q", 32'(acc_q_3), 32'd0);
    checkOutput("mid_rst_alu_a", 32'(alu_a_3), 32'd0);
    checkOutput("mid_rst_alu_b", 32'(alu_b_3), 32'd0);
    checkOutput("mid_rst_alu_ctrl", 32'(alu_ctrl_3), 32'd0);
    checkOutput("mid_rst_rsp_data", 32'(rsp_data_3), 32'd0);
    checkOutput("mid_rst_rsp_carry", 32'(rsp_carry_3), 32'd0);
    checkOutput("mid_rst_rsp_zero", 32'(rsp_zero_3), 32'd0);
    checkOutput("mid_rst_sticky", 32'(sticky_carry_3), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid_3) seen++;
    end
    checkOutput("mid_rst_no_rsp", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream issue stage for the 6-bit combinational ALU: accepts op commands over a valid/ready handshake and keeps an accumulator register.
- Drives registered ALU operands (A = accumulator, B = command immediate) plus the 4-bit control code, and samples the ALU's out/carry/zero after a fixed latency.
- Writes the ALU result back into the accumulator and presents it on a valid/ready response port.
- Lets the pin-limited top chain multi-step ALU computations without re-supplying operand A.

Parameters:
WIDTH, 6, operand/result width; must match ALU width.
ALU_LAT, 1, cycles operands are held on the ALU ports before the result is sampled; legal range 1..7.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  4  ALU control code, or LOAD (4'b1111) / CLEAR (4'b1110)
cmd_imm  input  WIDTH  operand B, or load value
alu_ctrl  output  4  control code to ALU
alu_a  output  WIDTH  operand A to ALU (accumulator)
alu_b  output  WIDTH  operand B to ALU
alu_out  input  WIDTH  ALU result
alu_carry  input  1  ALU carry/borrow
alu_zero  input  1  ALU zero flag
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_data  output  WIDTH  result (= new accumulator value)
rsp_carry  output  1  captured carry
rsp_zero  output  1  captured zero flag
acc_q  output  WIDTH  current accumulator
sticky_carry  output  1  OR of carries since reset/CLEAR (see Optional Feature)

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0 the state goes to IDLE.
- Reset values: acc_q, alu_ctrl, alu_a, alu_b, rsp_data, rsp_carry, rsp_zero, rsp_valid, sticky_carry and the latency counter all 0.
- Reset overrides everything, including mid-ISSUE or mid-RESP. Any in-flight command and result are discarded, with no response.
- States: IDLE, ISSUE, RESP.
- cmd_ready = (state==IDLE), decoded from state. rsp_valid = (state==RESP), registered.
- Handshake: a transfer occurs on an edge where valid&&ready. Neither ready nor valid may depend combinationally on the other side's valid/ready.
- IDLE, accept of an ALU op: latch alu_ctrl<=cmd_op, alu_a<=acc_q, alu_b<=cmd_imm, counter<=ALU_LAT-1, then go to ISSUE.
- IDLE, accept of LOAD: acc<=cmd_imm, rsp_data<=cmd_imm, rsp_carry<=0, rsp_zero<=(cmd_imm==0), then go to RESP. The ALU is not used.
- IDLE, accept of CLEAR: acc<=0, rsp_data<=0, rsp_carry<=0, rsp_zero<=1, sticky cleared, then go to RESP.
- ISSUE: alu_* held stable. While counter!=0, decrement. At counter==0: acc<=alu_out, rsp_data<=alu_out, rsp_carry<=alu_carry, rsp_zero<=alu_zero, then go to RESP.
- Latency: an ALU command accepted at edge N gives rsp_valid high after edge N+ALU_LAT+1. LOAD/CLEAR give rsp_valid high after edge N+1.
- RESP: rsp_* held stable until rsp_ready=1, then go to IDLE. No command is accepted in the same cycle as the response drains; minimum throughput is 1 command per ALU_LAT+2 cycles.
- Control codes other than LOAD/CLEAR are passed through unchecked. An unsupported code yields the ALU default (out=0, carry=0, zero=1), which is captured normally.
- alu_* retain their last issued values outside ISSUE.
- Width rule: all datapath is WIDTH bits with no sign extension. Carry is whatever the ALU reports.
- Elaboration error if ALU_LAT<1 or ALU_LAT>7.

Optional Feature:
- Macro ALU_SEQ_STICKY_CARRY_EN.
- Defined: a sticky register is set when an ISSUE capture has alu_carry=1. It is cleared by reset or by CLEAR, and drives sticky_carry.
- Not defined: no register; sticky_carry tied to 0.

Test Plan:
- Reset, then LOAD imm=5 with rsp_ready=1 -> cmd_ready=1 after reset; rsp_valid 1 cycle after accept; rsp_data=5, carry=0, zero=0; acc_q=5.
- From acc=5, ADD (0010) imm=3 with ALU_LAT=1 -> alu_a=5, alu_b=3 during ISSUE; rsp_valid 2 cycles after accept; rsp_data=8, carry=0; then SUB (0110) imm=9 -> rsp_data=6'h3F, carry=1, zero=0.
- Backpressure: hold rsp_ready=0 for 4 cycles after result -> rsp_valid and rsp_* stable; cmd_ready=0; offered cmd_valid ignored; release -> IDLE next cycle.
- ALU_LAT=3: ADD 0x20+0x20 -> operands stable 3 cycles; result 0, carry=1, zero=1 after edge N+4.
- Reset mid-ISSUE (rst_n low 1 cycle) -> all outputs 0, no rsp_valid pulse, cmd_ready=1 after the reset edge.
- With ALU_SEQ_STICKY_CARRY_EN: carry-producing ADD, then a non-carry op -> sticky_carry stays 1; CLEAR -> 0. Without the macro -> sticky_carry always 0.
